// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } i2c_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam int   BYTE_BITS = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output only follows
// the line once FILTER_LEN consecutive synchronized samples disagree with it.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Down-counter reloads whenever the sample agrees with the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 2'b11;
            cnt      <= CNT_LOAD;
            line_out <= 1'b1;
        end else begin
            sync <= {sync[0], line_in};
            if (sync[1] == line_out) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                line_out <= sync[1];
                cnt      <= CNT_LOAD;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_target_reg8.sv
// I2C target exposing a single 8-bit register, writable from the bus or the fabric.
//   state    | meaning
//   IDLE     | bus ignored until START
//   ADDR     | shifting in address + R/W
//   ADDR_ACK | driving ACK for our address
//   WR       | shifting in a data byte
//   WR_ACK   | driving ACK for a written byte
//   RD       | driving register snapshot MSB-first
//   RD_ACK   | SDA released, sampling master ACK/NACK
module i2c_target_reg8
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] reg_out,
    output logic       reg_wr,
    input  logic [7:0] reg_in,
    input  logic       reg_in_valid,
    output logic       busy
);

    i2c_state_t state, state_nxt;

    logic       scl_f, sda_f, scl_q, sda_q;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh;
    logic       rw_bit, mst_ack;
    logic       byte_done, addr_match, wr_fire;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk      (clk),
        .rst      (rst),
        .line_in  (scl_i),
        .line_out (scl_f)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk      (clk),
        .rst      (rst),
        .line_in  (sda_i),
        .line_out (sda_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_q;
    assign scl_fall   = ~scl_f & scl_q;
    assign start_det  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det   = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_done  = (bit_cnt == 4'(BYTE_BITS));
    assign addr_match = (rx_sh[7:1] == DEV_ADDR);
    assign wr_fire    = (state == WR) && scl_fall && byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All protocol transitions happen on SCL falls so SDA only moves while SCL is low.
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else if (scl_fall) begin
            case (state)
                ADDR:     if (byte_done) state_nxt = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK: state_nxt = rw_bit ? RD : WR;
                WR:       if (byte_done) state_nxt = WR_ACK;
                WR_ACK:   state_nxt = WR;
                RD:       if (byte_done) state_nxt = RD_ACK;
                RD_ACK:   state_nxt = (mst_ack == I2C_ACK) ? RD : IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        sda_o = 1'b1;
        sda_t = 1'b1;
        case (state)
            ADDR_ACK, WR_ACK: begin
                sda_o = 1'b0;
                sda_t = 1'b0;
            end
            RD: begin
                sda_o = tx_sh[7];
                sda_t = tx_sh[7];
            end
            default: begin
                sda_o = 1'b1;
                sda_t = 1'b1;
            end
        endcase
    end

    assign scl_o = 1'b1;
    assign scl_t = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 4'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
            rw_bit  <= 1'b0;
            mst_ack <= I2C_NACK;
            reg_out <= 8'h00;
            reg_wr  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            reg_wr <= wr_fire;
            if (wr_fire) begin
                reg_out <= rx_sh;
            end else if (reg_in_valid) begin
                reg_out <= reg_in;
            end

            if (stop_det) begin
                busy <= 1'b0;
            end else if (start_det) begin
                busy <= 1'b1;
            end

            if (start_det) begin
                bit_cnt <= 4'd0;
            end else if (scl_rise) begin
                if (state inside {ADDR, WR, RD}) begin
                    rx_sh   <= {rx_sh[6:0], sda_f};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (state == RD_ACK) begin
                    mst_ack <= sda_f;
                end
            end else if (scl_fall) begin
                case (state)
                    ADDR:     if (byte_done) rw_bit <= rx_sh[0];
                    ADDR_ACK: begin
                        bit_cnt <= 4'd0;
                        tx_sh   <= reg_out;
                    end
                    WR_ACK:   bit_cnt <= 4'd0;
                    RD:       if (!byte_done) tx_sh <= {tx_sh[6:0], 1'b1};
                    RD_ACK:   begin
                        bit_cnt <= 4'd0;
                        tx_sh   <= reg_out;
                    end
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_reg8.sv
// Directed bench for i2c_target_reg8: an open-drain bus master plus a
// transaction-level model of the register and ACK behaviour.
module tb_i2c_target_reg8;
    import i2c_pkg::*;

    localparam logic [6:0] DEV = 7'h50;
    localparam int         FL  = 4;
    localparam int         Q   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic [7:0] reg_out, reg_in;
    logic       reg_wr, reg_in_valid, busy;
    wire        sda_bus;

    assign sda_bus = sda_m & (sda_t | sda_o);

    always #5 clk = ~clk;

    i2c_target_reg8 #(.DEV_ADDR(DEV), .FILTER_LEN(FL)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_i        (scl_m),
        .scl_o        (scl_o),
        .scl_t        (scl_t),
        .sda_i        (sda_bus),
        .sda_o        (sda_o),
        .sda_t        (sda_t),
        .reg_out      (reg_out),
        .reg_wr       (reg_wr),
        .reg_in       (reg_in),
        .reg_in_valid (reg_in_valid),
        .busy         (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         wr_pulses = 0;
    int         exp_wr = 0;
    logic       run_cmp = 1'b0;
    logic       hold_reg = 1'b0;
    logic       must_release = 1'b0;
    logic       wr_prev = 1'b0;
    logic [7:0] exp_reg = 8'h00;
    logic       m_addr_phase = 1'b0;
    logic       m_wr_ok = 1'b0;
    logic       m_rd_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            if (!hold_reg) check("reg_out_model", reg_out, exp_reg);
            check("scl_released", {scl_o, scl_t}, 2'b11);
            if (must_release) check("sda_released", sda_t, 1'b1);
            check("reg_wr_width", reg_wr & wr_prev, 1'b0);
            if (reg_wr) wr_pulses++;
        end
        wr_prev = reg_wr;
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0;
        m_addr_phase = 1'b1;
        m_wr_ok = 1'b0;
        m_rd_ok = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
        m_wr_ok = 1'b0;
        m_rd_ok = 1'b0;
        wq(4);
    endtask

    task automatic i2c_bit(input logic b, input logic glitch, output logic r);
        wq(Q);
        sda_m = b;
        wq(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wq(4);
            sda_m = ~b;
            wq(FL - 1);
            sda_m = b;
            wq(Q - 4 - (FL - 1));
        end else begin
            wq(Q);
        end
        r = sda_bus;
        wq(Q);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, input string name);
        logic r, ack, exp_ack, is_data;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], glitch, r);
        is_data = !m_addr_phase && m_wr_ok;
        if (m_addr_phase) begin
            m_wr_ok = (d[7:1] == DEV) && !d[0];
            m_rd_ok = (d[7:1] == DEV) && d[0];
            exp_ack = (d[7:1] == DEV) ? I2C_ACK : I2C_NACK;
            m_addr_phase = 1'b0;
        end else begin
            exp_ack = m_wr_ok ? I2C_ACK : I2C_NACK;
        end
        if (is_data) begin
            hold_reg = 1'b1;
            exp_reg = d;
            exp_wr++;
        end
        i2c_bit(1'b1, 1'b0, ack);
        hold_reg = 1'b0;
        check(name, ack, exp_ack);
    endtask

    task automatic read_byte(input logic mack, input string name, output logic [7:0] got);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, 1'b0, r);
            got[i] = r;
        end
        check(name, got, m_rd_ok ? exp_reg : 8'hFF);
        i2c_bit(mack, 1'b0, r);
        if (mack == I2C_NACK) m_rd_ok = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] got;
        logic       r;
        logic [7:0] d;

        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        reg_in = 8'h00;
        reg_in_valid = 1'b0;
        wq(4);
        check("rst_reg_out", reg_out, 8'h00);
        check("rst_reg_wr", reg_wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", {sda_o, sda_t}, 2'b11);
        check("rst_scl", {scl_o, scl_t}, 2'b11);
        check("rst_state", dut.state, IDLE);
        rst = 1'b0;
        wq(2);
        run_cmp = 1'b1;

        // Plain write
        i2c_start();
        write_byte(8'hA0, 1'b0, "w1_addr_ack");
        check("w1_busy_mid", busy, 1'b1);
        write_byte(8'h3C, 1'b0, "w1_data_ack");
        i2c_stop();
        check("w1_reg_out", reg_out, 8'h3C);
        check("w1_wr_pulses", wr_pulses, 1);
        check("w1_busy_after_stop", busy, 1'b0);

        // Fabric load then read with master NACK
        reg_in = 8'hA5;
        reg_in_valid = 1'b1;
        hold_reg = 1'b1;
        exp_reg = 8'hA5;
        wq(1);
        reg_in_valid = 1'b0;
        hold_reg = 1'b0;
        wq(1);
        check("ld_reg_out", reg_out, 8'hA5);
        i2c_start();
        write_byte(8'hA1, 1'b0, "r1_addr_ack");
        read_byte(I2C_NACK, "r1_data_model", got);
        check("r1_data_lit", got, 8'hA5);
        wq(Q);
        check("r1_sda_after_nack", sda_t, 1'b1);
        check("r1_state_after_nack", dut.state, IDLE);
        i2c_stop();
        check("r1_wr_pulses", wr_pulses, exp_wr);

        // Wrong address: target must stay off the bus
        must_release = 1'b1;
        i2c_start();
        write_byte(8'hA2, 1'b0, "na_addr_nack");
        check("na_state", dut.state, IDLE);
        write_byte(8'h77, 1'b0, "na_data_nack");
        i2c_stop();
        must_release = 1'b0;
        check("na_reg_out", reg_out, 8'hA5);
        check("na_wr_pulses", wr_pulses, exp_wr);

        // Write then repeated START and read back
        i2c_start();
        write_byte(8'hA0, 1'b0, "rs_addr_w_ack");
        write_byte(8'h11, 1'b0, "rs_data_ack");
        i2c_start();
        write_byte(8'hA1, 1'b0, "rs_addr_r_ack");
        check("rs_busy", busy, 1'b1);
        read_byte(I2C_NACK, "rs_data_model", got);
        check("rs_data_lit", got, 8'h11);
        i2c_stop();
        check("rs_wr_pulses", wr_pulses, exp_wr);

        // Short SDA glitches while SCL is high on every data bit
        i2c_start();
        write_byte(8'hA0, 1'b0, "gl_addr_ack");
        write_byte(8'hC3, 1'b1, "gl_data_ack");
        i2c_stop();
        check("gl_reg_out", reg_out, 8'hC3);
        check("gl_wr_pulses", wr_pulses, exp_wr);

        // Reset while the target drives the data ACK
        i2c_start();
        write_byte(8'hA0, 1'b0, "rr_addr_ack");
        d = 8'h77;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], 1'b0, r);
        hold_reg = 1'b1;
        exp_reg = 8'h77;
        exp_wr++;
        wq(Q);
        sda_m = 1'b1;
        hold_reg = 1'b0;
        check("rr_ack_driven", sda_t, 1'b0);
        check("rr_reg_before", reg_out, 8'h77);
        hold_reg = 1'b1;
        exp_reg = 8'h00;
        rst = 1'b1;
        wq(1);
        check("rr_sda_release", sda_t, 1'b1);
        check("rr_reg_cleared", reg_out, 8'h00);
        check("rr_busy_cleared", busy, 1'b0);
        rst = 1'b0;
        hold_reg = 1'b0;
        m_wr_ok = 1'b0;
        m_rd_ok = 1'b0;
        wq(Q);
        scl_m = 1'b1;
        wq(2 * Q);
        scl_m = 1'b0;
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "rr2_addr_ack");
        write_byte(8'h5A, 1'b0, "rr2_data_ack");
        i2c_stop();
        check("rr2_reg_out", reg_out, 8'h5A);
        i2c_start();
        write_byte(8'hA1, 1'b0, "rr2_addr_r_ack");
        read_byte(I2C_NACK, "rr2_data_model", got);
        check("rr2_data_lit", got, 8'h5A);
        i2c_stop();
        check("rr2_wr_pulses", wr_pulses, exp_wr);
        check("rr2_busy", busy, 1'b0);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_reg8.md
I2C_TARGET_REG8 -- requirements
Module: i2c_target_reg8

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit target address the block answers to.
REQ-002 SHALL have parameter FILTER_LEN, default 4, the number of consecutive equal samples needed to accept a line change.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports scl_i, scl_o and scl_t (input/output/output, 1 bit each): SCL pad in, pad out, and tristate enable (1 = released).
REQ-006 SHALL have ports sda_i, sda_o and sda_t (input/output/output, 1 bit each): SDA pad in, pad out, and tristate enable (1 = released).
REQ-007 SHALL have port reg_out, output, 8 bits: the current register value.
REQ-008 SHALL have port reg_wr, output, 1 bit: one-cycle pulse when I2C has written reg_out.
REQ-009 SHALL have ports reg_in (input, 8 bits) and reg_in_valid (input, 1 bit): fabric-side load of the register.
REQ-010 SHALL have port busy, output, 1 bit: high from an accepted START until STOP.

Function
REQ-011 SHALL pass scl_i and sda_i through a 2-flop synchronizer and then a filter; the filtered value changes only after FILTER_LEN consecutive equal synchronized samples.
REQ-012 SHALL detect START as filtered SDA 1->0 while filtered SCL is 1, and STOP as filtered SDA 0->1 while filtered SCL is 1.
REQ-013 SHALL sample data on filtered SCL rising edges and change sda_o/sda_t only on filtered SCL falling edges.
REQ-014 SHALL hold scl_o=1 and scl_t=1 permanently (no clock stretching).
REQ-015 SHALL use the FSM states IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-016 SHALL go from any state to ADDR on START, including repeated START, and SHALL release SDA at that point.
REQ-017 SHALL go from any state to IDLE on STOP.
REQ-018 In ADDR, SHALL shift in 8 bits MSB-first; if bits[7:1]==DEV_ADDR it SHALL go to ADDR_ACK, otherwise to IDLE with SDA released.
REQ-019 In ADDR_ACK, SHALL drive SDA low for the 9th clock, then go to WR if R/W=0 or to RD if R/W=1.
REQ-020 In WR, after 8 bits, SHALL load reg_out, pulse reg_wr for exactly 1 cycle, and go to WR_ACK; WR_ACK SHALL drive SDA low, then return to WR.
REQ-021 In RD, SHALL snapshot reg_out at entry and drive it MSB-first, releasing SDA for 1-bits.
REQ-022 In RD, after the 8th bit, SHALL release SDA and sample the master ACK in RD_ACK: ACK (0) goes to RD, NACK (1) goes to IDLE.
REQ-023 SHALL load reg_in into reg_out on the next cycle when reg_in_valid=1, unless reg_wr fires that same cycle, in which case the I2C write wins.
REQ-024 SHALL ignore bus activity while in IDLE until START.

Reset
REQ-025 While rst=1, SHALL set state=IDLE, reg_out=8'h00, reg_wr=0, busy=0, sda_o=1, sda_t=1, scl_o=1, scl_t=1, filter and synchronizer flops =1, and bit counter =0.
REQ-026 SHALL release SDA on reset asserted mid-transfer, in the cycle after the rst sample, and SHALL ignore the bus until the next START.

Structure
REQ-027 SHALL place the state enumeration and the ACK/NACK bit constants in package i2c_pkg.
REQ-028 SHALL implement synchronizer and filter as sub-module i2c_line_filter, instantiated once for SCL and once for SDA.

Verification
REQ-029 Bench SHALL cover: START, 0xA0, 0x3C, STOP -> both bytes ACKed, reg_out=8'h3C, exactly one reg_wr pulse, busy low after STOP.
REQ-030 Bench SHALL cover: reg_in=8'hA5 with reg_in_valid, then START, 0xA1, master NACK, STOP -> target returns 8'hA5 MSB-first and releases SDA after the NACK.
REQ-031 Bench SHALL cover: START, 0xA2 -> address NACK (SDA stays released), state IDLE, reg_out unchanged.
REQ-032 Bench SHALL cover: write 0x11, repeated START, 0xA1, read -> 8'h11 returned with no STOP in between.
REQ-033 Bench SHALL cover: SDA glitch of FILTER_LEN-1 cycles while SCL is high -> no START/STOP detected, transfer unaffected.
REQ-034 Bench SHALL cover: rst pulsed during the ACK of a write -> sda_t=1 the next cycle, reg_out=8'h00, following transfer behaves normally.
